// File: rtl/inst_type_stage_pkg.sv
// Shared TSC opcode/function encodings, instruction-type codes and skid-buffer states
// for the registered multi-lane instruction-type stage.
package inst_type_stage_pkg;

  localparam logic [3:0] OPCODE_BNE   = 4'd0;
  localparam logic [3:0] OPCODE_BEQ   = 4'd1;
  localparam logic [3:0] OPCODE_BGZ   = 4'd2;
  localparam logic [3:0] OPCODE_BLZ   = 4'd3;
  localparam logic [3:0] OPCODE_ADI   = 4'd4;
  localparam logic [3:0] OPCODE_ORI   = 4'd5;
  localparam logic [3:0] OPCODE_LHI   = 4'd6;
  localparam logic [3:0] OPCODE_LWD   = 4'd7;
  localparam logic [3:0] OPCODE_SWD   = 4'd8;
  localparam logic [3:0] OPCODE_JMP   = 4'd9;
  localparam logic [3:0] OPCODE_JAL   = 4'd10;
  localparam logic [3:0] OPCODE_RTYPE = 4'd15;

  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;
  localparam logic [5:0] FUNC_NOP = 6'b111111;

  localparam logic [2:0] INSTTYPE_RTYPE  = 3'd0;
  localparam logic [2:0] INSTTYPE_LOAD   = 3'd1;
  localparam logic [2:0] INSTTYPE_STORE  = 3'd2;
  localparam logic [2:0] INSTTYPE_BRANCH = 3'd3;
  localparam logic [2:0] INSTTYPE_JUMP   = 3'd4;
  localparam logic [2:0] INSTTYPE_OUTPUT = 3'd5;
  localparam logic [2:0] INSTTYPE_NOP    = 3'd6;
  localparam logic [2:0] INSTTYPE_HALT   = 3'd7;

  localparam int NUM_TYPES = 8;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/inst_type_stage_class_lane.sv
// Combinational classifier for one instruction lane; an empty lane always reads as NOP
// so it can never be mistaken for a countable or halting instruction.
module inst_class_lane
  import inst_type_stage_pkg::*;
#(
  parameter bit HALT_MODE = 1'b1
) (
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  input  logic       lane_valid,
  output logic [2:0] inst_type
);

  always_comb begin
    inst_type = INSTTYPE_NOP;
    if (lane_valid) begin
      case (opcode)
        OPCODE_RTYPE: begin
          case (func)
            FUNC_JPR, FUNC_JRL: inst_type = INSTTYPE_JUMP;
            FUNC_WWD:           inst_type = INSTTYPE_OUTPUT;
            FUNC_NOP:           inst_type = INSTTYPE_NOP;
            FUNC_HLT:           inst_type = HALT_MODE ? INSTTYPE_HALT : INSTTYPE_RTYPE;
            default:            inst_type = INSTTYPE_RTYPE;
          endcase
        end
        OPCODE_ADI, OPCODE_ORI:                         inst_type = INSTTYPE_RTYPE;
        OPCODE_LHI, OPCODE_LWD:                         inst_type = INSTTYPE_LOAD;
        OPCODE_SWD:                                     inst_type = INSTTYPE_STORE;
        OPCODE_BNE, OPCODE_BEQ, OPCODE_BGZ, OPCODE_BLZ: inst_type = INSTTYPE_BRANCH;
        OPCODE_JMP, OPCODE_JAL:                         inst_type = INSTTYPE_JUMP;
        default:                                        inst_type = INSTTYPE_NOP;
      endcase
    end
  end

endmodule

// File: rtl/inst_type_stage.sv
// Registered multi-lane instruction-type stage: classifies each accepted bundle, squashes
// lanes younger than a HALT, buffers through a two-entry skid buffer and profiles retired types.
module inst_type_stage
  import inst_type_stage_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int WORD_W    = 16,
  parameter int CNT_W     = 16,
  parameter bit HALT_MODE = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*WORD_W-1:0]   in_inst,
  input  logic [LANES-1:0]          in_lane_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WORD_W-1:0]   out_inst,
  output logic [LANES*3-1:0]        out_type,
  output logic [LANES-1:0]          out_lane_valid,
  output logic                      halted,
  input  logic [2:0]                cnt_sel,
  input  logic                      cnt_clear,
  output logic [CNT_W-1:0]          cnt_value
);

  skid_state_e               state_q, state_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      halted_q, halted_d;
  logic [LANES*WORD_W-1:0]   main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [LANES*3-1:0]        main_type_q, main_type_d, skid_type_q, skid_type_d;
  logic [LANES-1:0]          main_lv_q, main_lv_d, skid_lv_q, skid_lv_d;
  logic [CNT_W-1:0]          cnt_q [NUM_TYPES];
  logic [CNT_W-1:0]          cnt_d [NUM_TYPES];

  logic [LANES*3-1:0]        raw_type, new_type;
  logic [LANES-1:0]          new_lv;
  logic                      new_has_halt;
  logic                      accept, drain;
  logic [2:0]                lane_cnt;
  logic [CNT_W+2:0]          cnt_sum;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    inst_class_lane #(
      .HALT_MODE(HALT_MODE)
    ) u_class (
      .opcode    (in_inst[i*WORD_W + WORD_W - 4 +: 4]),
      .func      (in_inst[i*WORD_W +: 6]),
      .lane_valid(in_lane_valid[i]),
      .inst_type (raw_type[i*3 +: 3])
    );
  end

  // Everything younger than the oldest valid HALT is dropped before it can retire.
  always_comb begin
    new_type     = raw_type;
    new_lv       = in_lane_valid;
    new_has_halt = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (new_has_halt) begin
        new_lv[i]          = 1'b0;
        new_type[i*3 +: 3] = INSTTYPE_NOP;
      end else if (in_lane_valid[i] && raw_type[i*3 +: 3] == INSTTYPE_HALT) begin
        new_has_halt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_type_d = main_type_q;
    main_lv_d   = main_lv_q;
    skid_inst_d = skid_inst_q;
    skid_type_d = skid_type_q;
    skid_lv_d   = skid_lv_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          main_inst_d = in_inst;
          main_type_d = new_type;
          main_lv_d   = new_lv;
          state_d     = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          main_inst_d = in_inst;
          main_type_d = new_type;
          main_lv_d   = new_lv;
        end else if (accept) begin
          skid_inst_d = in_inst;
          skid_type_d = new_type;
          skid_lv_d   = new_lv;
          state_d     = SKID_TWO;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (drain) begin
          main_inst_d = skid_inst_q;
          main_type_d = skid_type_q;
          main_lv_d   = skid_lv_q;
          state_d     = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    halted_d    = halted_q | (accept & new_has_halt);
    in_ready_d  = !halted_d && (state_d != SKID_TWO);
    out_valid_d = (state_d != SKID_EMPTY);
  end

  // Retire profiling: widened sum so a multi-lane increment can be clamped, clear dominates.
  always_comb begin
    lane_cnt = '0;
    cnt_sum  = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      cnt_d[t] = cnt_q[t];
      lane_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
        if (main_lv_q[i] && main_type_q[i*3 +: 3] == 3'(t)) lane_cnt = lane_cnt + 3'd1;
      end
      cnt_sum = {3'b000, cnt_q[t]} + {{CNT_W{1'b0}}, lane_cnt};
      if (cnt_clear) begin
        cnt_d[t] = '0;
      end else if (drain) begin
        cnt_d[t] = (|cnt_sum[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      main_inst_q <= '0;
      main_type_q <= '0;
      main_lv_q   <= '0;
      skid_inst_q <= '0;
      skid_type_q <= '0;
      skid_lv_q   <= '0;
      for (int t = 0; t < NUM_TYPES; t++) cnt_q[t] <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      main_inst_q <= main_inst_d;
      main_type_q <= main_type_d;
      main_lv_q   <= main_lv_d;
      skid_inst_q <= skid_inst_d;
      skid_type_q <= skid_type_d;
      skid_lv_q   <= skid_lv_d;
      for (int t = 0; t < NUM_TYPES; t++) cnt_q[t] <= cnt_d[t];
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = main_inst_q;
  assign out_type       = main_type_q;
  assign out_lane_valid = main_lv_q;
  assign halted         = halted_q;
  assign cnt_value      = cnt_q[cnt_sel];

endmodule

// File: tb/tb_inst_type_stage.sv
// Directed bench for inst_type_stage: two lanes, 4-bit counters, one instance with HALT
// classification enabled and a second sharing its inputs with HALT classification disabled.
module tb_inst_type_stage;

  localparam logic [2:0] T_RTYPE  = 3'd0;
  localparam logic [2:0] T_LOAD   = 3'd1;
  localparam logic [2:0] T_STORE  = 3'd2;
  localparam logic [2:0] T_BRANCH = 3'd3;
  localparam logic [2:0] T_JUMP   = 3'd4;
  localparam logic [2:0] T_OUTPUT = 3'd5;
  localparam logic [2:0] T_NOP    = 3'd6;
  localparam logic [2:0] T_HALT   = 3'd7;

  localparam logic [15:0] I_ADI  = 16'h4123;
  localparam logic [15:0] I_ORI  = 16'h5333;
  localparam logic [15:0] I_LHI  = 16'h6444;
  localparam logic [15:0] I_LWD  = 16'h7111;
  localparam logic [15:0] I_SWD  = 16'h8456;
  localparam logic [15:0] I_BNE  = 16'h0222;
  localparam logic [15:0] I_BGZ  = 16'h2666;
  localparam logic [15:0] I_JMP  = 16'h9ABC;
  localparam logic [15:0] I_JAL  = 16'hA555;
  localparam logic [15:0] I_WWD  = 16'hF01C;
  localparam logic [15:0] I_JPR  = 16'hF019;
  localparam logic [15:0] I_HLT  = 16'hF01D;
  localparam logic [15:0] I_NOPF = 16'hF03F;
  localparam logic [15:0] I_UNK  = 16'hB000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_inst = '0;
  logic [1:0]  in_lane_valid = '0;
  logic [2:0]  cnt_sel = '0;
  logic        cnt_clear = 1'b0;

  logic        in_ready, out_valid, halted;
  logic [31:0] out_inst;
  logic [5:0]  out_type;
  logic [1:0]  out_lane_valid;
  logic [3:0]  cnt_value;

  logic        nh_in_ready, nh_out_valid, nh_halted;
  logic [31:0] nh_out_inst;
  logic [5:0]  nh_out_type;
  logic [1:0]  nh_out_lane_valid;
  logic [3:0]  nh_cnt_value;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_type_stage #(.LANES(2), .WORD_W(16), .CNT_W(4), .HALT_MODE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_lane_valid(in_lane_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_type(out_type),
    .out_lane_valid(out_lane_valid), .halted(halted), .cnt_sel(cnt_sel),
    .cnt_clear(cnt_clear), .cnt_value(cnt_value)
  );

  inst_type_stage #(.LANES(2), .WORD_W(16), .CNT_W(4), .HALT_MODE(1'b0)) dut_nh (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nh_in_ready),
    .in_inst(in_inst), .in_lane_valid(in_lane_valid), .out_valid(nh_out_valid),
    .out_ready(out_ready), .out_inst(nh_out_inst), .out_type(nh_out_type),
    .out_lane_valid(nh_out_lane_valid), .halted(nh_halted), .cnt_sel(cnt_sel),
    .cnt_clear(cnt_clear), .cnt_value(nh_cnt_value)
  );

  task automatic drive_bundle(input logic [15:0] lane0, input logic [15:0] lane1,
                              input logic [1:0] lv);
    in_inst       = {lane1, lane0};
    in_lane_valid = lv;
    in_valid      = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    cnt_clear = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    vectors++; if (out_lane_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_lane_valid: got %b want 00", out_lane_valid); end
    vectors++; if (out_type !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_out_type: got %h want 0", out_type); end
    vectors++; if (out_inst !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_out_inst: got %h want 0", out_inst); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted: got %0b want 0", halted); end
    for (int t = 0; t < 8; t++) begin
      cnt_sel = 3'(t);
      #1;
      vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_cnt%0d: got %0d want 0", t, cnt_value); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk); drive_bundle(I_ADI, I_SWD, 2'b11);
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid: got %0b want 1", out_valid); end
    vectors++; if (out_type !== {T_STORE, T_RTYPE}) begin miscompares++; $display("[TB] FAIL basic_type: got %h want %h", out_type, {T_STORE, T_RTYPE}); end
    vectors++; if (out_inst !== {I_SWD, I_ADI}) begin miscompares++; $display("[TB] FAIL basic_inst: got %h want %h", out_inst, {I_SWD, I_ADI}); end
    vectors++; if (out_lane_valid !== 2'b11) begin miscompares++; $display("[TB] FAIL basic_lv: got %b want 11", out_lane_valid); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_drained: got %0b want 0", out_valid); end
    cnt_sel = T_RTYPE; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL basic_cnt_rtype: got %0d want 1", cnt_value); end
    cnt_sel = T_STORE; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL basic_cnt_store: got %0d want 1", cnt_value); end
    cnt_sel = T_LOAD; #1;
    vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("[TB] FAIL basic_cnt_load: got %0d want 0", cnt_value); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); drive_bundle(I_LWD, I_BNE, 2'b11);
    @(posedge clk); #1;
    vectors++; if (out_type !== {T_BRANCH, T_LOAD}) begin miscompares++; $display("[TB] FAIL b2b_type1: got %h want %h", out_type, {T_BRANCH, T_LOAD}); end
    @(negedge clk); drive_bundle(I_WWD, I_JPR, 2'b11);
    @(posedge clk); #1;
    vectors++; if (out_type !== {T_JUMP, T_OUTPUT}) begin miscompares++; $display("[TB] FAIL b2b_type2: got %h want %h", out_type, {T_JUMP, T_OUTPUT}); end
    vectors++; if (out_inst !== {I_JPR, I_WWD}) begin miscompares++; $display("[TB] FAIL b2b_inst2: got %h want %h", out_inst, {I_JPR, I_WWD}); end
    @(negedge clk); drive_bundle(I_NOPF, I_UNK, 2'b11);
    @(posedge clk); #1;
    vectors++; if (out_type !== {T_NOP, T_NOP}) begin miscompares++; $display("[TB] FAIL b2b_type3: got %h want %h", out_type, {T_NOP, T_NOP}); end
    @(negedge clk); drive_bundle(I_ORI, I_LHI, 2'b01);
    @(posedge clk); #1;
    vectors++; if (out_type !== {T_NOP, T_RTYPE}) begin miscompares++; $display("[TB] FAIL b2b_type4: got %h want %h", out_type, {T_NOP, T_RTYPE}); end
    vectors++; if (out_lane_valid !== 2'b01) begin miscompares++; $display("[TB] FAIL b2b_lv4: got %b want 01", out_lane_valid); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drained: got %0b want 0", out_valid); end
    cnt_sel = T_NOP; #1;
    vectors++; if (cnt_value !== 4'd2) begin miscompares++; $display("[TB] FAIL b2b_cnt_nop: got %0d want 2", cnt_value); end
    cnt_sel = T_LOAD; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL b2b_cnt_load: got %0d want 1", cnt_value); end
    cnt_sel = T_JUMP; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL b2b_cnt_jump: got %0d want 1", cnt_value); end
    cnt_sel = T_RTYPE; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL b2b_cnt_rtype: got %0d want 1", cnt_value); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk); drive_bundle(I_LWD, I_SWD, 2'b11);
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready1: got %0b want 1", in_ready); end
    @(negedge clk); drive_bundle(I_JMP, I_ORI, 2'b11);
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready2: got %0b want 0", in_ready); end
    @(negedge clk); drive_bundle(I_BNE, I_BNE, 2'b11);
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready3: got %0b want 0", in_ready); end
    vectors++; if (out_inst !== {I_SWD, I_LWD}) begin miscompares++; $display("[TB] FAIL bp_hold_inst: got %h want %h", out_inst, {I_SWD, I_LWD}); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_hold_valid: got %0b want 1", out_valid); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_inst !== {I_ORI, I_JMP}) begin miscompares++; $display("[TB] FAIL bp_second_inst: got %h want %h", out_inst, {I_ORI, I_JMP}); end
    vectors++; if (out_type !== {T_RTYPE, T_JUMP}) begin miscompares++; $display("[TB] FAIL bp_second_type: got %h want %h", out_type, {T_RTYPE, T_JUMP}); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ready4: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drained: got %0b want 0", out_valid); end
    cnt_sel = T_BRANCH; #1;
    vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("[TB] FAIL bp_cnt_branch: got %0d want 0", cnt_value); end
    cnt_sel = T_JUMP; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL bp_cnt_jump: got %0d want 1", cnt_value); end
  endtask

  task automatic test_halt();
    do_reset();
    @(negedge clk); drive_bundle(I_HLT, I_JMP, 2'b11);
    @(posedge clk); #1;
    vectors++; if (out_lane_valid !== 2'b01) begin miscompares++; $display("[TB] FAIL halt_lv: got %b want 01", out_lane_valid); end
    vectors++; if (out_type !== {T_NOP, T_HALT}) begin miscompares++; $display("[TB] FAIL halt_type: got %h want %h", out_type, {T_NOP, T_HALT}); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_flag: got %0b want 1", halted); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_ready: got %0b want 0", in_ready); end
    vectors++; if (nh_out_type !== {T_JUMP, T_RTYPE}) begin miscompares++; $display("[TB] FAIL nohalt_type: got %h want %h", nh_out_type, {T_JUMP, T_RTYPE}); end
    vectors++; if (nh_out_lane_valid !== 2'b11) begin miscompares++; $display("[TB] FAIL nohalt_lv: got %b want 11", nh_out_lane_valid); end
    vectors++; if (nh_halted !== 1'b0) begin miscompares++; $display("[TB] FAIL nohalt_flag: got %0b want 0", nh_halted); end
    @(negedge clk); drive_bundle(I_ADI, I_ADI, 2'b11);
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_no_accept: got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_ready_sticky: got %0b want 0", in_ready); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_sticky: got %0b want 1", halted); end
    cnt_sel = T_HALT; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL halt_cnt_halt: got %0d want 1", cnt_value); end
    cnt_sel = T_JUMP; #1;
    vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("[TB] FAIL halt_cnt_jump: got %0d want 0", cnt_value); end
    vectors++; if (nh_cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL nohalt_cnt_jump: got %0d want 1", nh_cnt_value); end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    cnt_sel = T_RTYPE;
    for (int b = 0; b < 9; b++) begin
      @(negedge clk); drive_bundle(I_ADI, I_ADI, (b == 8) ? 2'b01 : 2'b11);
      @(posedge clk); #1;
      if (b == 7) begin
        vectors++; if (cnt_value !== 4'd14) begin miscompares++; $display("[TB] FAIL sat_cnt14: got %0d want 14", cnt_value); end
      end
      if (b == 8) begin
        vectors++; if (cnt_value !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_cnt16: got %0d want 15", cnt_value); end
      end
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (cnt_value !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_cnt17: got %0d want 15", cnt_value); end
    cnt_sel = T_NOP; #1;
    vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("[TB] FAIL sat_cnt_nop: got %0d want 0", cnt_value); end
    cnt_sel = T_RTYPE;
    @(negedge clk); drive_bundle(I_ADI, I_ADI, 2'b11);
    @(negedge clk); in_valid = 1'b0; cnt_clear = 1'b1;
    @(posedge clk); #1;
    vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("[TB] FAIL clear_wins: got %0d want 0", cnt_value); end
    @(negedge clk); cnt_clear = 1'b0;
  endtask

  task automatic test_reset_in_two();
    do_reset();
    @(negedge clk); drive_bundle(I_ADI, I_SWD, 2'b11);
    @(negedge clk); drive_bundle(I_LWD, I_LWD, 2'b11);
    @(negedge clk); drive_bundle(I_ORI, I_ORI, 2'b11); out_ready = 1'b0;
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL two_ready: got %0b want 0", in_ready); end
    cnt_sel = T_RTYPE; #1;
    vectors++; if (cnt_value !== 4'd1) begin miscompares++; $display("[TB] FAIL two_cnt_rtype: got %0d want 1", cnt_value); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_valid: got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_ready: got %0b want 1", in_ready); end
    vectors++; if (out_inst !== 32'd0) begin miscompares++; $display("[TB] FAIL arst_inst: got %h want 0", out_inst); end
    vectors++; if (out_type !== 6'd0) begin miscompares++; $display("[TB] FAIL arst_type: got %h want 0", out_type); end
    vectors++; if (out_lane_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL arst_lv: got %b want 00", out_lane_valid); end
    vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("[TB] FAIL arst_cnt: got %0d want 0", cnt_value); end
    @(negedge clk); reset = 1'b0; out_ready = 1'b1; drive_bundle(I_JAL, I_BGZ, 2'b11);
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_valid: got %0b want 1", out_valid); end
    vectors++; if (out_type !== {T_BRANCH, T_JUMP}) begin miscompares++; $display("[TB] FAIL post_rst_type: got %h want %h", out_type, {T_BRANCH, T_JUMP}); end
    vectors++; if (out_inst !== {I_BGZ, I_JAL}) begin miscompares++; $display("[TB] FAIL post_rst_inst: got %h want %h", out_inst, {I_BGZ, I_JAL}); end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_discard: got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_halt();
    test_saturate();
    test_reset_in_two();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_type_stage.md
# inst_type_stage

Registered, multi-lane successor to the combinational instruction-type decoder. It accepts a bundle of up to LANES 16-bit TSC instructions per cycle over a valid/ready handshake and classifies each lane into an inst_type. Each bundle is presented one cycle later with a full-throughput skid buffer. The block also adds an optional HALT class, sticky halt detection with younger-lane squash, and per-type saturating retire counters for profiling. It sits between fetch and the hazard/control unit.

## Interface
- LANES, 2, instructions per bundle (1..4); lane 0 is oldest
- WORD_W, 16, instruction width; opcode = [WORD_W-1:WORD_W-4], func = [5:0]
- CNT_W, 16, width of each per-type counter
- HALT_MODE, 1, 1: FUNC_HLT classifies as INSTTYPE_HALT and arms halt logic; 0: HLT is INSTTYPE_RTYPE
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- in_valid  in  1  bundle offered
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_inst  in  LANES*WORD_W  lane i at [i*WORD_W +: WORD_W]
- in_lane_valid  in  LANES  per-lane occupancy
- out_valid  out  1  decoded bundle available
- out_ready  in  1  consumer accepts
- out_inst  out  LANES*WORD_W  registered copy of accepted instructions
- out_type  out  LANES*3  lane i type at [i*3 +: 3]
- out_lane_valid  out  LANES  occupancy after squash
- halted  out  1  sticky; a HALT has been accepted
- cnt_sel  in  3  inst_type whose counter drives cnt_value
- cnt_clear  in  1  synchronous clear of all counters
- cnt_value  out  CNT_W  counter for cnt_sel, combinational read

## Operation
- Classification per lane, identical to the existing decoder.
  - OPCODE_RTYPE: FUNC_JPR/JRL → JUMP; FUNC_WWD → OUTPUT; FUNC_NOP (6'b111111) → NOP; FUNC_HLT → HALT if HALT_MODE, else RTYPE; other funcs → RTYPE.
  - ADI/ORI → RTYPE; LHI/LWD → LOAD; SWD → STORE; BNE/BEQ/BGZ/BLZ → BRANCH; JMP/JAL → JUMP.
  - Any other opcode → NOP.
- Invalid lanes (in_lane_valid=0) classify as NOP and are never counted.
- Halt squash:
  - In the accepted bundle, the lowest-index valid HALT lane stays valid.
  - All higher lanes have out_lane_valid cleared. Their out_type is forced to NOP.
  - halted sets on that acceptance.
- Once halted=1, in_ready=0 until reset. Buffered bundles still drain.
- Counters:
  - One CNT_W counter per type 0..7. HALT uses index 7.
  - On each output handshake (out_valid & out_ready), each counter adds the popcount of valid lanes of its type. Squashed lanes are not counted.
  - Counters saturate at all-ones; the sum is computed CNT_W+3 wide, then clamped.
  - cnt_clear wins over a simultaneous increment: the result is 0 that cycle.

## Timing
- Latency: bundle accepted at edge N → out_valid from edge N, i.e. visible the cycle after acceptance.
- Throughput: one bundle per cycle while out_ready=1.
- Skid buffer has 2 entries (main + skid). States:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without out handshake.
  - ONE → EMPTY on out handshake without accept.
  - TWO → ONE on out handshake. The skid entry moves to main.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO or when halted. It never depends combinationally on out_ready.
- Simultaneous accept and out handshake in ONE: state stays ONE, main loads the new bundle.
- out_* are stable while out_valid & !out_ready.
- Reset, including mid-bundle: state EMPTY, out_valid=0, in_ready=1, out_lane_valid=0, out_type=0, out_inst=0, halted=0, all counters 0. In-flight bundles are discarded.

## Structure
- Shared constants.v holds OPCODE_*, FUNC_*, INSTTYPE_* (including new INSTTYPE_HALT=3'd7), and FUNC_HLT.
- One sub-module, inst_class_lane: combinational per-lane classifier taking opcode, func, lane_valid and HALT_MODE. It is instantiated LANES times via generate.
- The skid buffer, squash logic and counters stay in inst_type_stage.

## Test plan
- LANES=2, bundle {ADI, SWD}, out_ready=1 → next cycle out_type={RTYPE, STORE}; RTYPE and STORE counters each +1.
- out_ready=0 for 3 cycles with in_valid=1 → two bundles accepted, in_ready=0 on the third cycle, no loss. Releasing out_ready yields both bundles in order.
- Bundle {HLT, JMP}, HALT_MODE=1 → out_lane_valid=2'b01, lane 1 type NOP, halted=1, in_ready stays 0. JUMP count unchanged, HALT count 1.
- Same bundle with HALT_MODE=0 → types {RTYPE, JUMP}, halted stays 0.
- CNT_W=4: feed 17 RTYPE lanes → RTYPE counter reads 15. cnt_clear together with an increment → 0.
- Assert reset while in state TWO → all outputs reach reset values asynchronously. First post-reset bundle is emitted with latency 1.
